shared_bus_sel_arbiter: RTL and testbench
=========================================

// Module: shared_bus_sel_arbiter
// PURPOSE
//  Round-robin arbiter and access sequencer for a shared bus/RAM resource.
//  Up to 8 requesters, e.g. CPU, sprite DMA and video fetch on one work RAM.
//  Registered grant index plus one-cold active-low select vector, which equals
//  a 74138-style decode of the grant. Drives chip-select/OE lines that the
//  board decoders currently produce from fixed address bits.
//  Times each access window and returns a per-requester completion pulse.
// PARAMETERS
//  NUM_REQ     4                   number of requesters, legal 2..8
//  IDX_W       $clog2(NUM_REQ)     width of grant index
//  ACC_CYCLES  3                   clocks per access window, legal 1..15
//  TURN_CYCLES 1                   extra bus-turnaround clocks after each access, legal 0..3
// PORTS
//  clk        in   1        single system clock, rising edge
//  reset      in   1        asynchronous, active-high reset
//  req        in   NUM_REQ  level request per requester; held until its ack
//  ack        out  NUM_REQ  one-clock completion pulse to the granted requester
//  gnt_idx    out  IDX_W    index of current/last granted requester
//  gnt_valid  out  1        high while an access window is open
//  sel_n      out  NUM_REQ  active-low one-cold select; bit gnt_idx low iff gnt_valid
//  busy       out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, immediate):
//   state=IDLE, sel_n=all 1, gnt_valid=0, ack=0, gnt_idx=0, busy=0, prio ptr=0.
//  All outputs are registered and glitch-free.
//  States:
//   IDLE   : all sel_n high.
//            If |req, select the first set bit scanning ptr, ptr+1, ... with wrap at NUM_REQ-1 -> 0.
//            Load gnt_idx and cnt=ACC_CYCLES-1, then go to ACCESS. Otherwise stay in IDLE.
//   ACCESS : gnt_valid=1, sel_n[gnt_idx]=0, decrement cnt each clock.
//            In the cycle cnt==0: ack[gnt_idx]=1 and ptr<=gnt_idx+1 (wrap).
//            Next state is GAP if TURN_CYCLES>0, else IDLE.
//   GAP    : all sel_n high, gnt_valid=0. Stay TURN_CYCLES clocks, then go to IDLE.
//  Latency: req sampled high at edge N -> sel_n low from edge N+1, for exactly ACC_CYCLES clocks.
//  Turnaround: between two grants, sel_n is all-high for at least 1+TURN_CYCLES clocks.
//   Those clocks are the GAP cycles plus one IDLE arbitration cycle.
//  Access period under continuous load = ACC_CYCLES+TURN_CYCLES+1.
//  Fairness: rotating priority. Under full load, every requester is granted within NUM_REQ periods.
//  req deasserted mid-ACCESS: the window still completes and ack is still pulsed (committed cycle).
//  req deasserted in IDLE before sampling: no grant is issued.
//  ack is never asserted outside the last ACCESS cycle and never on more than one bit.
//  gnt_idx holds its value after ACCESS until the next grant.
//  Invariants, checked by assertion:
//   - at most one sel_n bit low;
//   - sel_n == ~(gnt_valid << gnt_idx);
//   - gnt_valid implies busy;
//   - gnt_idx < NUM_REQ.
//  Reset asserted mid-access: sel_n goes all-high without a clock edge and no ack is produced.
//   The aborted requester keeps req high and is re-arbitrated from ptr=0.
// TESTING  (NUM_REQ=4, ACC_CYCLES=3, TURN_CYCLES=1)
//  1. reset=1 -> sel_n=4'b1111, gnt_valid=0, ack=4'b0000, busy=0, with no clock running.
//  2. req=4'b0100 from edge 0 -> sel_n=4'b1011 at edges 1-3, ack=4'b0100 only in cycle 3;
//     sel_n=1111 at edges 4-5; with req held, regrant at edge 6.
//  3. req=4'b1111 held -> grant order 0,1,2,3,0 with sel_n low at edges 1,6,11,16,21,
//     each for 3 clocks, and 2 all-high clocks between windows.
//  4. req=4'b0010, dropped after edge 1 -> sel_n=4'b1101 still for 3 clocks,
//     ack[1] pulses once, then IDLE with no regrant.
//  5. Async reset pulse mid-ACCESS (req[3] granted) -> sel_n=1111 immediately;
//     after release with req=4'b1001, grant goes to 0 (ptr reset).
//  6. 10k cycles of random req, with requesters holding req until ack ->
//     invariants hold, every held request is acked within 4*5 clocks, and no lost or double acks.

Source files
------------

// File: rtl/shared_bus_sel_arbiter_if.sv
// Shared-bus arbiter signal bundle: level requests in; grant, select and completion out.
// master = arbiter side, slave = requester/board side.
interface shared_bus_sel_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic [NUM_REQ-1:0] sel_n;
  logic               busy;

  modport master (
    input  req,
    output ack, gnt_idx, gnt_valid, sel_n, busy
  );

  modport slave (
    output req,
    input  ack, gnt_idx, gnt_valid, sel_n, busy
  );
endinterface

// File: rtl/shared_bus_sel_arbiter.sv
// Round-robin arbiter/sequencer for a shared RAM: grants one requester per timed access
// window, drives a one-cold active-low select, pulses ack on the window's last cycle.
module shared_bus_sel_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = $clog2(NUM_REQ),
  parameter int ACC_CYCLES  = 3,
  parameter int TURN_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  shared_bus_sel_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  localparam logic [3:0] ACC_LOAD = 4'(ACC_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

  logic [1:0]         r_state;
  logic [3:0]         r_cnt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic               r_gnt_valid;
  logic [NUM_REQ-1:0] r_sel_n;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;

  logic [1:0]         w_state_nxt;
  logic [3:0]         w_cnt_nxt;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic               w_valid_nxt;
  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0]   w_pick;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Requests rotated so bit 0 is the current priority holder.
  assign w_rot = NUM_REQ'({bus.req, bus.req} >> r_ptr);

  always_comb begin
    w_pick = r_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pick = wrap_add(r_ptr, i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_gnt_idx;
    w_ack_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_state_nxt = S_ACCESS;
          w_idx_nxt   = w_pick;
          w_cnt_nxt   = ACC_LOAD;
          if (ACC_CYCLES == 1) w_ack_nxt[w_pick] = 1'b1;
        end
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_ptr_nxt = wrap_add(r_gnt_idx, 1);
          if (TURN_CYCLES > 0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          // ack is registered, so raise it one edge before the counter reaches zero.
          if (r_cnt == 4'd1) w_ack_nxt[r_gnt_idx] = 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_valid_nxt = (w_state_nxt == S_ACCESS);

  // Outputs are registered from next-state so they change only on the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_sel_n     <= '1;
      r_ack       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_gnt_valid <= w_valid_nxt;
      r_sel_n     <= w_valid_nxt ? ~(NUM_REQ'(1) << w_idx_nxt) : '1;
      r_ack       <= w_ack_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.ack       = r_ack;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.sel_n     = r_sel_n;
  assign bus.busy      = r_busy;

  a_sel_onecold: assert property (@(posedge clk) disable iff (reset) $onehot0(~bus.sel_n));
  a_sel_decode:  assert property (@(posedge clk) disable iff (reset)
                   bus.sel_n == ~(NUM_REQ'(bus.gnt_valid) << bus.gnt_idx));
  a_valid_busy:  assert property (@(posedge clk) disable iff (reset) bus.gnt_valid |-> bus.busy);
  a_idx_range:   assert property (@(posedge clk) disable iff (reset) int'(bus.gnt_idx) < NUM_REQ);
  a_ack_grant:   assert property (@(posedge clk) disable iff (reset)
                   (bus.ack != '0) |-> (bus.gnt_valid && bus.ack == (NUM_REQ'(1) << bus.gnt_idx)));

endmodule

// File: tb/tb_shared_bus_sel_arbiter.sv
// Directed-vector and random-load bench for shared_bus_sel_arbiter (4 requesters, 3-clock access, 1-clock gap).
module tb_shared_bus_sel_arbiter;

  logic clk;
  logic clk_en;
  logic reset;
  int   n_chk;
  int   n_err;

  shared_bus_sel_arbiter_if #(.NUM_REQ(4)) bus ();

  shared_bus_sel_arbiter #(
    .NUM_REQ(4), .IDX_W(2), .ACC_CYCLES(3), .TURN_CYCLES(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] sel_n;
    logic [3:0] ack;
    logic       vld;
    logic       busy;
    logic [1:0] idx;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [3:0] pending;
  int         waitc [4];
  logic [3:0] exp_sel;
  logic [3:0] exp_ack;
  int         w;
  int         ph;

  initial begin
    n_chk   = 0;
    n_err   = 0;
    clk_en  = 1'b0;
    bus.req = 4'b0000;
    reset   = 1'b1;
    pending = 4'b0000;
    #2;
    // Reset with the clock stopped.
    chk("rst_sel_n", 32'(bus.sel_n), 32'hF);
    chk("rst_gnt_valid", 32'(bus.gnt_valid), 32'h0);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_gnt_idx", 32'(bus.gnt_idx), 32'h0);
    clk_en = 1'b1;
    step();
    reset = 1'b0;

    // Row k: req applied before edge k, outputs expected after edge k.
    tbl[0]  = '{4'b0100, 4'b1011, 4'b0000, 1'b1, 1'b1, 2'd2};
    tbl[1]  = '{4'b0100, 4'b1011, 4'b0000, 1'b1, 1'b1, 2'd2};
    tbl[2]  = '{4'b0100, 4'b1011, 4'b0100, 1'b1, 1'b1, 2'd2};
    tbl[3]  = '{4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b1, 2'd2};
    tbl[4]  = '{4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd2};
    tbl[5]  = '{4'b0100, 4'b1011, 4'b0000, 1'b1, 1'b1, 2'd2};
    tbl[6]  = '{4'b0100, 4'b1011, 4'b0000, 1'b1, 1'b1, 2'd2};
    tbl[7]  = '{4'b0100, 4'b1011, 4'b0100, 1'b1, 1'b1, 2'd2};
    tbl[8]  = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1, 2'd2};
    tbl[9]  = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd2};
    tbl[10] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd2};
    tbl[11] = '{4'b0010, 4'b1101, 4'b0000, 1'b1, 1'b1, 2'd1};
    tbl[12] = '{4'b0000, 4'b1101, 4'b0000, 1'b1, 1'b1, 2'd1};
    tbl[13] = '{4'b0000, 4'b1101, 4'b0010, 1'b1, 1'b1, 2'd1};
    tbl[14] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1, 2'd1};
    tbl[15] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd1};
    tbl[16] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd1};

    for (int k = 0; k < 17; k++) begin
      bus.req = tbl[k].req;
      step();
      chk($sformatf("vec%0d_sel_n", k), 32'(bus.sel_n), 32'(tbl[k].sel_n));
      chk($sformatf("vec%0d_ack", k), 32'(bus.ack), 32'(tbl[k].ack));
      chk($sformatf("vec%0d_gnt_valid", k), 32'(bus.gnt_valid), 32'(tbl[k].vld));
      chk($sformatf("vec%0d_busy", k), 32'(bus.busy), 32'(tbl[k].busy));
      chk($sformatf("vec%0d_gnt_idx", k), 32'(bus.gnt_idx), 32'(tbl[k].idx));
    end

    // Full load from a fresh pointer: 5-clock period, grants rotate 0,1,2,3,0.
    do_reset();
    bus.req = 4'b1111;
    for (int e = 0; e < 25; e++) begin
      step();
      w  = e / 5;
      ph = e % 5;
      exp_sel = (ph < 3) ? ~(4'b0001 << (w % 4)) : 4'b1111;
      exp_ack = (ph == 2) ? (4'b0001 << (w % 4)) : 4'b0000;
      chk($sformatf("load%0d_sel_n", e), 32'(bus.sel_n), 32'(exp_sel));
      chk($sformatf("load%0d_ack", e), 32'(bus.ack), 32'(exp_ack));
      chk($sformatf("load%0d_busy", e), 32'(bus.busy), (ph != 4) ? 32'h1 : 32'h0);
      chk($sformatf("load%0d_gnt_idx", e), 32'(bus.gnt_idx), 32'(w % 4));
    end

    // Async reset in the middle of requester 3's window.
    do_reset();
    bus.req = 4'b1000;
    step();
    chk("abort_pre_sel_n", 32'(bus.sel_n), 32'h7);
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("abort_sel_n", 32'(bus.sel_n), 32'hF);
    chk("abort_gnt_valid", 32'(bus.gnt_valid), 32'h0);
    chk("abort_ack", 32'(bus.ack), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    step();
    chk("abort_hold_ack", 32'(bus.ack), 32'h0);
    reset   = 1'b0;
    bus.req = 4'b1001;
    step();
    chk("abort_regrant_idx", 32'(bus.gnt_idx), 32'h0);
    chk("abort_regrant_sel_n", 32'(bus.sel_n), 32'hE);

    // Random requesters holding req until their ack.
    bus.req = 4'b0000;
    do_reset();
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int c = 0; c < 10040; c++) begin
      if (c < 10000) begin
        for (int i = 0; i < 4; i++) begin
          if (!pending[i] && $urandom_range(0, 2) == 0) begin
            pending[i] = 1'b1;
            waitc[i]   = 0;
          end
        end
      end
      bus.req = pending;
      step();
      if ($countones(~bus.sel_n) > 1) chk("rnd_sel_onecold", 32'($countones(~bus.sel_n)), 32'h1);
      if (bus.ack != 4'b0000) begin
        chk("rnd_ack_grant", 32'(bus.ack), 32'(4'b0001 << bus.gnt_idx));
        chk("rnd_ack_pending", 32'(bus.ack & ~pending), 32'h0);
      end
      for (int i = 0; i < 4; i++) begin
        if (pending[i]) begin
          waitc[i]++;
          if (waitc[i] == 21) chk($sformatf("rnd_latency_req%0d", i), 32'(waitc[i]), 32'd20);
          if (bus.ack[i]) pending[i] = 1'b0;
        end
      end
    end
    chk("rnd_lost_ack", 32'(pending), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
